// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit limits and load sanitising helper for the
// multi-digit up/down counter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MIN : d;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit register with load, up/down step and boundary detection.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic       Clk,
  input  logic       rst,
  input  logic       step,
  input  logic       up,
  input  logic       load,
  input  bcd_digit_t load_val,
  input  logic       hold,
  output bcd_digit_t digit,
  output logic       boundary
);

  assign boundary = up ? (digit == BCD_MAX) : (digit == BCD_MIN);

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      digit <= BCD_MIN;
    end else if (load) begin
      digit <= bcd_sanitize(load_val);
    end else if (step && !hold) begin
      if (up) digit <= (digit == BCD_MAX) ? BCD_MIN : digit + 4'd1;
      else    digit <= (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_updown_multi.sv
// Parametrised multi-digit BCD up/down counter with validated load, wrap or
// saturate, and cascadable TermCnt. BCD_UPDOWN_STICKY_OVF_EN adds OvfSticky.
module bcd_updown_multi
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SATURATE   = 0
) (
  input  logic                    Clk,
  input  logic                    rst,
  input  logic                    En,
  input  logic                    UpOrDown,
  input  logic                    Load,
  input  logic [4*NUM_DIGITS-1:0] LoadVal,
  output logic [4*NUM_DIGITS-1:0] Count,
  output logic                    TermCnt,
`ifdef BCD_UPDOWN_STICKY_OVF_EN
  output logic                    OvfSticky,
`endif
  output logic                    LoadErr
);

  logic [NUM_DIGITS-1:0] bnd;
  logic [NUM_DIGITS-1:0] step;
  logic                  advance;
  logic                  all_bnd;
  logic                  hold;
  logic                  load_bad;

  assign advance = En & ~Load;
  assign all_bnd = &bnd;
  assign TermCnt = advance & all_bnd;
  // Saturation freezes every digit; all of them would otherwise roll over.
  assign hold    = (SATURATE != 0) & all_bnd;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_first
      assign step[i] = advance;
    end else begin : g_ripple
      assign step[i] = step[i-1] & bnd[i-1];
    end

    bcd_digit_cell u_cell (
      .Clk      (Clk),
      .rst      (rst),
      .step     (step[i]),
      .up       (UpOrDown),
      .load     (Load),
      .load_val (LoadVal[4*i +: 4]),
      .hold     (hold),
      .digit    (Count[4*i +: 4]),
      .boundary (bnd[i])
    );
  end

  always_comb begin
    load_bad = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (LoadVal[4*k +: 4] > BCD_MAX) load_bad = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) LoadErr <= 1'b0;
    else      LoadErr <= Load & load_bad;
  end

`ifdef BCD_UPDOWN_STICKY_OVF_EN
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst)         OvfSticky <= 1'b0;
    else if (Load)    OvfSticky <= 1'b0;
    else if (TermCnt) OvfSticky <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_bcd_updown_multi.sv
// Bench for bcd_updown_multi: 4-digit wrap and saturate instances plus a
// two-stage 1-digit cascade, all compared against integer reference models.
module tb_bcd_updown_multi;

  logic        Clk = 1'b0;
  logic        rst;
  logic        En;
  logic        UpOrDown;
  logic        Load;
  logic [15:0] LoadVal;

  logic [15:0] cnt_w, cnt_s;
  logic        tc_w, tc_s, err_w, err_s;
  logic [3:0]  cnt_lo, cnt_hi;
  logic        tc_lo, tc_hi, err_lo, err_hi;
`ifdef BCD_UPDOWN_STICKY_OVF_EN
  logic        ovf_w, ovf_s, ovf_lo, ovf_hi;
`endif

  int n_vec = 0;
  int n_err = 0;

  // reference state: plain integers
  int m_w, m_s, m_c;
  bit e_w, e_s, e_lo, e_hi;
  bit o_w, o_s, o_lo, o_hi;

  always #5 Clk = ~Clk;

  bcd_updown_multi #(.NUM_DIGITS(4), .SATURATE(0)) dut_w (
    .Clk(Clk), .rst(rst), .En(En), .UpOrDown(UpOrDown), .Load(Load),
    .LoadVal(LoadVal), .Count(cnt_w), .TermCnt(tc_w),
`ifdef BCD_UPDOWN_STICKY_OVF_EN
    .OvfSticky(ovf_w),
`endif
    .LoadErr(err_w));

  bcd_updown_multi #(.NUM_DIGITS(4), .SATURATE(1)) dut_s (
    .Clk(Clk), .rst(rst), .En(En), .UpOrDown(UpOrDown), .Load(Load),
    .LoadVal(LoadVal), .Count(cnt_s), .TermCnt(tc_s),
`ifdef BCD_UPDOWN_STICKY_OVF_EN
    .OvfSticky(ovf_s),
`endif
    .LoadErr(err_s));

  bcd_updown_multi #(.NUM_DIGITS(1), .SATURATE(0)) dut_lo (
    .Clk(Clk), .rst(rst), .En(En), .UpOrDown(UpOrDown), .Load(Load),
    .LoadVal(LoadVal[3:0]), .Count(cnt_lo), .TermCnt(tc_lo),
`ifdef BCD_UPDOWN_STICKY_OVF_EN
    .OvfSticky(ovf_lo),
`endif
    .LoadErr(err_lo));

  bcd_updown_multi #(.NUM_DIGITS(1), .SATURATE(0)) dut_hi (
    .Clk(Clk), .rst(rst), .En(tc_lo), .UpOrDown(UpOrDown), .Load(Load),
    .LoadVal(LoadVal[7:4]), .Count(cnt_hi), .TermCnt(tc_hi),
`ifdef BCD_UPDOWN_STICKY_OVF_EN
    .OvfSticky(ovf_hi),
`endif
    .LoadErr(err_hi));

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int load_value(input logic [31:0] lv, input int nd);
    int v, pw, d;
    v = 0;
    pw = 1;
    for (int i = 0; i < nd; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d <= 9) v += d * pw;
      pw *= 10;
    end
    return v;
  endfunction

  function automatic bit load_bad(input logic [31:0] lv, input int nd);
    bit b;
    b = 1'b0;
    for (int i = 0; i < nd; i++) if (lv[4*i +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  function automatic int next_val(input int v, input bit up, input bit sat, input int maxv);
    if (up) return (v == maxv) ? (sat ? v : 0) : v + 1;
    else    return (v == 0) ? (sat ? 0 : maxv) : v - 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_regs();
    chk("count_wrap", 32'(cnt_w), to_bcd(m_w));
    chk("count_sat", 32'(cnt_s), to_bcd(m_s));
    chk("count_casc", {24'd0, cnt_hi, cnt_lo}, to_bcd(m_c));
    chk("loaderr_wrap", 32'(err_w), 32'(e_w));
    chk("loaderr_sat", 32'(err_s), 32'(e_s));
    chk("loaderr_lo", 32'(err_lo), 32'(e_lo));
    chk("loaderr_hi", 32'(err_hi), 32'(e_hi));
`ifdef BCD_UPDOWN_STICKY_OVF_EN
    chk("ovf_wrap", 32'(ovf_w), 32'(o_w));
    chk("ovf_sat", 32'(ovf_s), 32'(o_s));
    chk("ovf_lo", 32'(ovf_lo), 32'(o_lo));
    chk("ovf_hi", 32'(ovf_hi), 32'(o_hi));
`endif
  endtask

  task automatic model_reset();
    m_w = 0; m_s = 0; m_c = 0;
    e_w = 0; e_s = 0; e_lo = 0; e_hi = 0;
    o_w = 0; o_s = 0; o_lo = 0; o_hi = 0;
  endtask

  task automatic cyc(input bit ld, input logic [15:0] lv, input bit en, input bit ud);
    bit xw, xs, xlo, xhi;
    @(negedge Clk);
    Load = ld; LoadVal = lv; En = en; UpOrDown = ud;
    #1;
    xw  = en && !ld && (ud ? (m_w == 9999) : (m_w == 0));
    xs  = en && !ld && (ud ? (m_s == 9999) : (m_s == 0));
    xlo = en && !ld && (ud ? (m_c % 10 == 9) : (m_c % 10 == 0));
    xhi = xlo && (ud ? (m_c / 10 == 9) : (m_c / 10 == 0));
    chk("termcnt_wrap", 32'(tc_w), 32'(xw));
    chk("termcnt_sat", 32'(tc_s), 32'(xs));
    chk("termcnt_lo", 32'(tc_lo), 32'(xlo));
    chk("termcnt_hi", 32'(tc_hi), 32'(xhi));
    if (ld) begin
      m_w = load_value(32'(lv), 4);
      m_s = m_w;
      m_c = load_value(32'(lv), 2);
      o_w = 0; o_s = 0; o_lo = 0; o_hi = 0;
    end else begin
      if (en) begin
        m_w = next_val(m_w, ud, 1'b0, 9999);
        m_s = next_val(m_s, ud, 1'b1, 9999);
        m_c = next_val(m_c, ud, 1'b0, 99);
      end
      o_w |= xw; o_s |= xs; o_lo |= xlo; o_hi |= xhi;
    end
    e_w  = ld && load_bad(32'(lv), 4);
    e_s  = e_w;
    e_lo = ld && (lv[3:0] > 4'd9);
    e_hi = ld && (lv[7:4] > 4'd9);
    @(posedge Clk);
    #1;
    check_regs();
  endtask

  logic [15:0] corner [8] = '{16'h9999, 16'h0000, 16'h9998, 16'h0001,
                              16'h0999, 16'h1000, 16'h0099, 16'hA3F7};

  initial begin
    rst = 1'b0; En = 1'b0; UpOrDown = 1'b1; Load = 1'b0; LoadVal = '0;
    model_reset();
    #3;
    check_regs();
    @(negedge Clk);
    rst = 1'b1;

    // count to 0005 then pull reset between edges
    cyc(1'b1, 16'h0000, 1'b0, 1'b1);
    repeat (5) cyc(1'b0, 16'h0000, 1'b1, 1'b1);
    chk("count_before_reset", 32'(cnt_w), 32'h0005);
    @(posedge Clk);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_regs();
    @(posedge Clk);
    #1;
    check_regs();
    @(negedge Clk);
    rst = 1'b1;

    // wrap / saturate at the top
    cyc(1'b1, 16'h9998, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, 16'h0000, 1'b1, 1'b1);

    // down to zero, hold/wrap, then reverse with no dead cycle
    cyc(1'b1, 16'h0002, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b1);

    // ripple across digits
    cyc(1'b1, 16'h0199, 1'b0, 1'b1);
    cyc(1'b0, 16'h0000, 1'b1, 1'b1);
    chk("ripple_up", 32'(cnt_w), 32'h0200);
    cyc(1'b1, 16'h1000, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("ripple_down", 32'(cnt_w), 32'h0999);

    // load priority and digit validation
    cyc(1'b1, 16'hA3F7, 1'b1, 1'b1);
    chk("load_sanitized", 32'(cnt_w), 32'h0307);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1);
    cyc(1'b1, 16'h1234, 1'b1, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0);

    // cascade: two 1-digit stages count 00 -> 10
    cyc(1'b1, 16'h0000, 1'b0, 1'b1);
    repeat (10) cyc(1'b0, 16'h0000, 1'b1, 1'b1);
    chk("cascade_ten", {24'd0, cnt_hi, cnt_lo}, 32'h10);
    cyc(1'b1, 16'h0000, 1'b0, 1'b1);

    // randomized phase, biased toward boundaries
    for (int n = 0; n < 600; n++) begin
      logic [15:0] lv;
      if ($urandom_range(0, 1) == 0) lv = corner[$urandom_range(0, 7)];
      else                           lv = 16'($urandom);
      cyc($urandom_range(0, 9) == 0, lv, $urandom_range(0, 3) != 0,
          $urandom_range(0, 5) != 0 ? UpOrDown : ~UpOrDown);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
